// File: rtl/weight_stream_pkg.sv
// Shared definitions for the weight streaming source/sink pair: FSM state
// encoding and the sizing helpers used to derive row count and address width.
package weight_stream_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } stream_state_t;

  function automatic int calc_out_depth(input int tensor_size, input int par_dim_0);
    return tensor_size / par_dim_0;
  endfunction

  // One extra bit so the counter can hold the full row count.
  function automatic int calc_addr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/weight_stream_sink_ram.sv
// Single-write, single-read, read-first row RAM with a two-stage ce0-gated
// read pipeline that carries a "row already written" tag alongside the data.
module weight_stream_sink_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int IDX_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ce0,
  input  logic [ADDR_WIDTH-1:0] address0,
  input  logic [ADDR_WIDTH-1:0] fill_count,
  output logic [DATA_WIDTH-1:0] q0,
  output logic                  q0_valid
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] stage0_data_reg;
  logic                  stage0_tag_reg;
  logic [DATA_WIDTH-1:0] q0_reg;
  logic                  q0_valid_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The tag uses the pre-update count, so a same-cycle write reads as unwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage0_data_reg <= '0;
      stage0_tag_reg  <= 1'b0;
      q0_reg          <= '0;
      q0_valid_reg    <= 1'b0;
    end else if (ce0) begin
      if (address0 < DEPTH_A) begin
        stage0_data_reg <= mem[address0[IDX_W-1:0]];
      end else begin
        stage0_data_reg <= '0;
      end
      stage0_tag_reg <= (address0 < fill_count);
      q0_reg         <= stage0_data_reg;
      q0_valid_reg   <= stage0_tag_reg;
    end
  end

  assign q0       = q0_reg;
  assign q0_valid = q0_valid_reg;

endmodule

// File: rtl/weight_stream_sink.sv
// Receiving end of the weight stream: packs valid/ready beats into RAM rows and
// exposes them through a ROM-compatible address0/ce0/q0 read port.
module weight_stream_sink
  import weight_stream_pkg::*;
#(
  parameter int WEIGHT_TENSOR_SIZE_DIM_0 = 32,
  parameter int WEIGHT_PRECISION_0       = 16,
  parameter int WEIGHT_PARALLELISM_DIM_0 = 1,
  parameter int WEIGHT_PARALLELISM_DIM_1 = 1,
  parameter int OUT_DEPTH  = calc_out_depth(WEIGHT_TENSOR_SIZE_DIM_0, WEIGHT_PARALLELISM_DIM_0),
  parameter int ADDR_WIDTH = calc_addr_width(OUT_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WEIGHT_PRECISION_0-1:0] data_in [WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1],
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  input  logic                          restart,
  output logic                          load_done,
  output logic [ADDR_WIDTH-1:0]         fill_count,
  input  logic [ADDR_WIDTH-1:0]         address0,
  input  logic                          ce0,
  output logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM_DIM_0*WEIGHT_PARALLELISM_DIM_1-1:0] q0,
  output logic                          q0_valid
);

  localparam int P     = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1;
  localparam int W     = WEIGHT_PRECISION_0;
  localparam int IDX_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(OUT_DEPTH - 1);

  stream_state_t         state_reg, state_next;
  logic [ADDR_WIDTH-1:0] fill_count_reg, fill_count_next;
  logic                  handshake;
  logic [W*P-1:0]        packed_beat;

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_pack
      assign packed_beat[W*gi +: W] = data_in[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= LOAD;
      fill_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      fill_count_reg <= fill_count_next;
    end
  end

  // Ready depends only on state and restart, never on valid.
  always_comb begin
    state_next      = state_reg;
    fill_count_next = fill_count_reg;
    data_in_ready   = 1'b0;
    handshake       = 1'b0;
    if (restart) begin
      state_next      = LOAD;
      fill_count_next = '0;
    end else begin
      case (state_reg)
        LOAD: begin
          data_in_ready = 1'b1;
          handshake     = data_in_valid;
          if (data_in_valid) begin
            fill_count_next = fill_count_reg + ADDR_WIDTH'(1);
            if (fill_count_reg == LAST_ROW) begin
              state_next = FULL;
            end
          end
        end
        FULL: begin
          data_in_ready = 1'b0;
        end
        default: begin
          state_next = LOAD;
        end
      endcase
    end
  end

  assign load_done  = (state_reg == FULL);
  assign fill_count = fill_count_reg;

  weight_stream_sink_ram #(
    .DATA_WIDTH (W*P),
    .DEPTH      (OUT_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk        (clk),
    .rst        (rst),
    .we         (handshake),
    .waddr      (fill_count_reg[IDX_W-1:0]),
    .wdata      (packed_beat),
    .ce0        (ce0),
    .address0   (address0),
    .fill_count (fill_count_reg),
    .q0         (q0),
    .q0_valid   (q0_valid)
  );

endmodule
